// File: rtl/pp_tree_pipe_pkg.sv
// pp_tree_pkg: sizing helpers shared by the pipelined partial-product tree
// and its 3:2 compression level. All functions are elaboration-time only.
package pp_tree_pkg;

  localparam int MAX_PP  = 32;
  localparam int MAX_LPS = 8;

  // Number of rows left after 'levels' 3:2 levels; a level never goes below 2 rows.
  function automatic int rows_after(input int n, input int levels);
    int r;
    r = n;
    for (int i = 0; i < levels; i++) begin
      if (r > 2) r = r - r / 3;
    end
    return r;
  endfunction

  // Number of 3:2 levels needed to reduce n rows down to 2.
  function automatic int tree_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    for (int i = 0; i < MAX_PP; i++) begin
      if (r > 2) begin
        r = r - r / 3;
        l = l + 1;
      end
    end
    return l;
  endfunction

  // Register stages in the tree: one per group of lps levels, at least one.
  function automatic int pipe_stages(input int n, input int lps);
    int l;
    int s;
    l = tree_levels(n);
    s = (l + lps - 1) / lps;
    return (s < 1) ? 1 : s;
  endfunction

  // Row offset of tree segment 'seg' (rows entering level 'seg') in the flat row bus.
  function automatic int row_offset(input int n, input int seg);
    int off;
    off = 0;
    for (int j = 0; j < MAX_PP; j++) begin
      if (j < seg) off = off + rows_after(n, j);
    end
    return off;
  endfunction

endpackage

// File: rtl/pp_tree_pipe_csa_level.sv
// csa_level: one combinational Wallace 3:2 level. Each triple of rows becomes a
// sum row and a majority (carry) row; leftover rows pass straight through.
// Carry rows are shifted left by one for the next level, except in the final
// level (LAST=1) where the carry is left in its pre-shift form.
module csa_level
  import pp_tree_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int WIDTH = 64,
  parameter bit LAST  = 1'b0
) (
  input  logic [N_IN*WIDTH-1:0]                rows_in,
  output logic [rows_after(N_IN, 1)*WIDTH-1:0] rows_out
);

  localparam int N_TRI  = N_IN / 3;
  localparam int N_PASS = N_IN % 3;

  // Full-adder compression of each row triple; outputs interleave sum, carry.
  for (genvar t = 0; t < N_TRI; t++) begin : gen_tri
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] maj;

    assign a   = rows_in[(3*t)*WIDTH +: WIDTH];
    assign b   = rows_in[(3*t+1)*WIDTH +: WIDTH];
    assign c   = rows_in[(3*t+2)*WIDTH +: WIDTH];
    assign maj = (a & b) | (a & c) | (b & c);

    assign rows_out[(2*t)*WIDTH +: WIDTH] = a ^ b ^ c;

    if (LAST) begin : gen_raw
      assign rows_out[(2*t+1)*WIDTH +: WIDTH] = maj;
    end else begin : gen_shift
      assign rows_out[(2*t+1)*WIDTH +: WIDTH] = maj << 1;
    end
  end

  // Rows that do not fill a triple are carried to the next level unchanged.
  for (genvar p = 0; p < N_PASS; p++) begin : gen_pass
    assign rows_out[(2*N_TRI+p)*WIDTH +: WIDTH] = rows_in[(3*N_TRI+p)*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/pp_tree_pipe.sv
// pp_tree_pipe: pipelined Wallace reduction of NUM_PP partial products to a
// carry-save pair, with a register stage every LEVELS_PER_STAGE levels and a
// valid/ready handshake that supports per-stage stalls and bubble collapsing.
// Optional macro PP_TREE_PIPE_RESOLVE_EN adds a final carry-propagate stage
// and the 'result' port.
module pp_tree_pipe
  import pp_tree_pkg::*;
#(
  parameter int NUM_PP           = 16,
  parameter int WIDTH            = 64,
  parameter int LEVELS_PER_STAGE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_PP*WIDTH-1:0] pp_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        sum,
  output logic [WIDTH-1:0]        carry
`ifdef PP_TREE_PIPE_RESOLVE_EN
  ,
  output logic [WIDTH-1:0]        result
`endif
);

  localparam int L = tree_levels(NUM_PP);
  localparam int S = pipe_stages(NUM_PP, LEVELS_PER_STAGE);
`ifdef PP_TREE_PIPE_RESOLVE_EN
  localparam int RES = 1;
`else
  localparam int RES = 0;
`endif
  localparam int ST       = S + RES;
  localparam int SEG_ROWS = row_offset(NUM_PP, L + 1);

  logic [ST-1:0]             v;
  logic [ST:0]               ready;
  logic [ST-1:0]             up_valid;
  logic [ST-1:0]             stage_load;
  logic [SEG_ROWS*WIDTH-1:0] seg_rows;
  logic [WIDTH-1:0]          tree_sum;
  logic [WIDTH-1:0]          tree_carry;

  // Per-stage ready chain: a stage can take new data if empty or draining.
  always_comb begin
    ready      = '0;
    up_valid   = '0;
    stage_load = '0;
    ready[ST]  = out_ready;
    for (int k = ST - 1; k >= 0; k--) begin
      ready[k] = !v[k] || ready[k+1];
    end
    up_valid[0] = in_valid;
    for (int k = 1; k < ST; k++) begin
      up_valid[k] = v[k-1];
    end
    stage_load = ready[ST-1:0] & up_valid;
  end

  // Valid bits advance wherever a stage is ready; reset empties the pipe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else begin
      v <= (v & ~ready[ST-1:0]) | (up_valid & ready[ST-1:0]);
    end
  end

  assign seg_rows[NUM_PP*WIDTH-1:0] = pp_in;

  if (L == 0) begin : gen_no_levels
    logic [2*WIDTH-1:0] stage_q;

    // Two input rows need no compression; a single stage just registers them.
    always_ff @(posedge clk) begin
      if (stage_load[0]) stage_q <= seg_rows;
    end

    // Half-add the two rows so the pair still means sum + (carry << 1).
    assign tree_sum   = stage_q[WIDTH-1:0] ^ stage_q[2*WIDTH-1:WIDTH];
    assign tree_carry = stage_q[WIDTH-1:0] & stage_q[2*WIDTH-1:WIDTH];
  end else begin : gen_tree
    for (genvar lv = 0; lv < L; lv++) begin : gen_lvl
      localparam int N_OUT   = rows_after(NUM_PP, lv + 1);
      localparam int N_IN    = rows_after(NUM_PP, lv);
      localparam int IN_OFF  = row_offset(NUM_PP, lv);
      localparam int OUT_OFF = row_offset(NUM_PP, lv + 1);
      localparam bit AT_REG  = (((lv + 1) % LEVELS_PER_STAGE) == 0) || ((lv + 1) == L);
      localparam int STG     = lv / LEVELS_PER_STAGE;

      logic [N_OUT*WIDTH-1:0] lvl_out;

      csa_level #(
        .N_IN  (N_IN),
        .WIDTH (WIDTH),
        .LAST  (lv == L - 1)
      ) u_csa (
        .rows_in  (seg_rows[IN_OFF*WIDTH +: N_IN*WIDTH]),
        .rows_out (lvl_out)
      );

      if (AT_REG) begin : gen_reg
        logic [N_OUT*WIDTH-1:0] stage_q;

        // Stage boundary: capture this level's rows when the stage loads.
        always_ff @(posedge clk) begin
          if (stage_load[STG]) stage_q <= lvl_out;
        end

        assign seg_rows[OUT_OFF*WIDTH +: N_OUT*WIDTH] = stage_q;
      end else begin : gen_comb
        assign seg_rows[OUT_OFF*WIDTH +: N_OUT*WIDTH] = lvl_out;
      end
    end

    assign tree_sum   = seg_rows[(SEG_ROWS-2)*WIDTH +: WIDTH];
    assign tree_carry = seg_rows[(SEG_ROWS-1)*WIDTH +: WIDTH];
  end

`ifdef PP_TREE_PIPE_RESOLVE_EN
  logic [WIDTH-1:0] res_sum;
  logic [WIDTH-1:0] res_carry;
  logic [WIDTH-1:0] res_value;

  // Extra stage resolves the carry-save pair; sum/carry travel alongside it.
  always_ff @(posedge clk) begin
    if (stage_load[S]) begin
      res_sum   <= tree_sum;
      res_carry <= tree_carry;
      res_value <= tree_sum + (tree_carry << 1);
    end
  end

  assign sum    = out_valid ? res_sum   : '0;
  assign carry  = out_valid ? res_carry : '0;
  assign result = out_valid ? res_value : '0;
`else
  assign sum   = out_valid ? tree_sum   : '0;
  assign carry = out_valid ? tree_carry : '0;
`endif

  assign in_ready  = ready[0];
  assign out_valid = v[ST-1];

endmodule

// File: doc/pp_tree_pipe.md
# pp_tree_pipe

Parametrised, pipelined successor to the 16x64 partial-product compression tree. It reduces NUM_PP partial products of WIDTH bits through Wallace-style 3:2 carry-save levels, with a register stage after every LEVELS_PER_STAGE levels. A valid/ready handshake on both sides supports per-stage stalls and bubble collapsing. It sits between the partial-product generator and the final carry-propagate adder of the single-cycle/pipelined multiplier.

## Interface
- NUM_PP, default 16: number of partial products; legal range 2..32.
- WIDTH, default 64: operand and result width; all arithmetic is modulo 2^WIDTH.
- LEVELS_PER_STAGE, default 2: number of CSA levels between pipeline registers; legal range 1..8.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  pp_in holds a valid operand set.
- in_ready  out  1  stage 0 accepts this cycle.
- pp_in  in  NUM_PP*WIDTH  partial products; P[i] = pp_in[i*WIDTH +: WIDTH].
- out_valid  out  1  sum/carry are valid.
- out_ready  in  1  downstream accepts.
- sum  out  WIDTH  carry-save sum vector.
- carry  out  WIDTH  carry vector; result = sum + (carry << 1) mod 2^WIDTH.
- result  out  WIDTH  resolved sum; exists only with PP_TREE_PIPE_RESOLVE_EN.

## Operation
- Level count L = tree_levels(NUM_PP). Each level maps n to n - floor(n/3) rows, iterating until 2 rows remain. Examples: 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 gives L=6; NUM_PP=2 gives L=0; NUM_PP=3 gives L=1.
- Each 3:2 level outputs per triple s = a^b^c and c = maj(a,b,c).
  - Carry rows are shifted left 1 before they enter the next level; bit WIDTH-1 shifted out is discarded.
  - Leftover rows (n mod 3) pass through unchanged.
- Final stage presents the 2 remaining rows as sum (the unshifted row) and carry (pre-shift form), so the downstream adder computes sum + (carry << 1).
- Pipeline depth S = max(1, ceil(L / LEVELS_PER_STAGE)). Stage k holds a valid bit v[k] plus its row data.
- Stage k loads when ready[k] = !v[k] || ready[k+1]; the last stage uses ready[S] = out_ready.
  - in_ready = ready[0].
  - A bubble in any stage is filled while downstream is stalled (bubble collapse).
- out_valid = v[S-1]. sum/carry hold stable while out_valid && !out_ready.
- Transaction order is preserved. There is no dropping or duplication under any stall pattern.

## Timing
- Reset: all v[k] = 0; out_valid = 0; sum = 0; carry = 0; result = 0. in_ready = 1 in the first cycle after deassertion.
- Latency: a set accepted at edge t appears with out_valid at edge t+S-1 (visible in cycle t+S-1 onward), with no stalls. Example: NUM_PP=16, LEVELS_PER_STAGE=2 gives S=3.
- Throughput: 1 set per cycle while out_ready = 1.
- Simultaneous in_valid and full pipeline with out_ready = 1: accept and emit in the same cycle.
- in_ready is combinational from out_ready and the valid bits. There is no combinational path from pp_in to any output.
- rst_n asserted mid-operation: all in-flight sets are discarded immediately. Data registers may retain values, but outputs are forced to 0 while out_valid = 0.

## Configuration
- PP_TREE_PIPE_RESOLVE_EN defined:
  - Adds one extra register stage containing the carry-propagate add. Latency becomes S+1.
  - The result port is present; sum/carry stay aligned with result.
  - The handshake rules extend to the extra stage.
- Undefined: no result port, no adder, latency S.

## Structure
- Package pp_tree_pkg contains:
  - function tree_levels(n);
  - function rows_after(n, levels);
  - function pipe_stages(n, lps);
  - localparam limits MAX_PP=32 and MAX_LPS=8.
- Sub-module csa_level (parameters N_IN, WIDTH): one combinational 3:2 level, N_IN rows in, rows_after(N_IN,1) rows out, carry shift included. The top instantiates it L times via generate and places registers on stage boundaries.

## Test plan
- Defaults, P0=P3=P5=15, others 0, out_ready=1: after 3 cycles, sum+(carry<<1) = 0x2D and out_valid pulses for 1 cycle.
- Defaults, all 16 inputs 0xFFFF_FFFF_FFFF_FFFF: resolved value 0xFFFF_FFFF_FFFF_FFF0 (wrap, carry-out discarded).
- 3 back-to-back sets (values 1, 2, 3 in P0); out_ready low for 5 cycles, then high: outputs 1, 2, 3 in order, each held stable while stalled, and in_ready low once full.
- Single set, then out_ready low with 1 gap cycle before a second set: the bubble collapses, and both sets are delivered in order when out_ready rises.
- rst_n pulsed low for 1 cycle with 2 sets in flight: out_valid=0 immediately, no stale output after release, and the next set returns correctly.
- NUM_PP=3, WIDTH=8, LEVELS_PER_STAGE=1 (S=1), and the RESOLVE_EN build: inputs 0x80,0x80,0x01 give result 0x01, with latency 1 and 2 respectively.
